// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and frame constants shared by the tx arbiter and future rx blocks
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_t;

    localparam int   DATA_BITS     = 8;
    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: per-requester byte handshake (valid/data in, one-hot ready out)
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [DATA_BITS*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter with synchronous clear, one-cycle tick at DIV-1
module uart_baud_tick #(
    parameter int CLOCK_RATE = 40_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(DIV - 1);

    // count 0..DIV-1 and wrap; clr parks the counter at 0 between frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (clr || tick) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 UART TX line; define UART_TX_PARITY_EN for an even parity bit
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int CLOCK_RATE = 40_000_000,
    parameter  int BAUD_RATE  = 9600,
    parameter  int NUM_REQ    = 4,
    parameter  int STOP_BITS  = 1,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_arbiter_if.slave      req,
    output logic                  tx,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  frame_done
);

    uart_state_t          state, state_next;
    logic [IDW-1:0]       rr_ptr;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] data_q;
    logic                 tick;
    logic                 any_valid;
    logic [IDW:0]         sh, sum;
    logic [IDW-1:0]       pos, winner;
    logic [NUM_REQ-1:0]   rot;

    uart_baud_tick #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == IDLE),
        .tick (tick)
    );

    // rotate requests so rr_ptr+1 lands on bit 0, pick the lowest set bit, rotate the index back
    always_comb begin
        any_valid = |req.req_valid;
        sh        = {1'b0, rr_ptr} + (IDW+1)'(1);
        rot       = NUM_REQ'({req.req_valid, req.req_valid} >> sh);
        pos       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) pos = IDW'(i);
        sum       = sh + {1'b0, pos};
        winner    = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : sum[IDW-1:0];
    end

    // state register; async reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next state and line outputs; bit_idx counts data bits in DATA and stop bits in STOP
    always_comb begin
        state_next    = state;
        tx            = TX_IDLE_LEVEL;
        busy          = state != IDLE;
        frame_done    = 1'b0;
        req.req_ready = (state == IDLE && any_valid) ? NUM_REQ'(1) << winner : '0;
        case (state)
            IDLE:   if (any_valid) state_next = START;
            START: begin
                tx = 1'b0;
                if (tick) state_next = DATA;
            end
`ifdef UART_TX_PARITY_EN
            DATA: begin
                tx = data_q[bit_idx];
                if (tick && bit_idx == 3'(DATA_BITS - 1)) state_next = PARITY;
            end
            PARITY: begin
                tx = ^data_q;
                if (tick) state_next = STOP;
            end
`else
            DATA: begin
                tx = data_q[bit_idx];
                if (tick && bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
            end
`endif
            STOP: begin
                frame_done = tick && bit_idx == 3'(STOP_BITS - 1);
                if (frame_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // capture the granted byte and owner; bit index restarts whenever the state changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= IDW'(NUM_REQ - 1);
            grant_id <= '0;
            data_q   <= '0;
            bit_idx  <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                data_q   <= req.req_data[DATA_BITS*winner +: DATA_BITS];
                grant_id <= winner;
                rr_ptr   <= winner;
            end
            if (tick) bit_idx <= (state != state_next) ? 3'd0 : bit_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, frame timing and reset abort (DIV=16, NUM_REQ=4)
module tb_uart_tx_arbiter;

    localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_a, busy_a, fd_a, tx_b, busy_b, fd_b;
    logic [1:0] gid_a, gid_b;
    int         checks = 0;
    int         errors = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus_a ();
    uart_tx_arbiter_if #(.NUM_REQ(4)) bus_b ();

    uart_tx_arbiter #(.CLOCK_RATE(160), .BAUD_RATE(10), .NUM_REQ(4), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(bus_a), .tx(tx_a), .busy(busy_a),
        .grant_id(gid_a), .frame_done(fd_a)
    );

    uart_tx_arbiter #(.CLOCK_RATE(160), .BAUD_RATE(10), .NUM_REQ(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(bus_b), .tx(tx_b), .busy(busy_b),
        .grant_id(gid_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at the negedge of the transfer cycle; checks every cycle of the frame that follows
    task automatic expect_frame(input bit b, input logic [7:0] d, input int sb, input int gid,
                                input bit drop, input string tag);
        int   len = (9 + sb + PAR) * DIV;
        int   k;
        logic et;
        @(posedge clk);
        #1;
        if (drop) begin
            if (b) bus_b.req_valid = '0;
            else   bus_a.req_valid = '0;
        end
        check({tag, "_gid"}, b ? gid_b : gid_a, gid);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            k  = (c - 1) / DIV;
            et = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : (k == 9 && PAR == 1) ? ^d : 1'b1;
            check({tag, "_tx"}, b ? tx_b : tx_a, et);
            check({tag, "_busy"}, b ? busy_b : busy_a, 1);
            check({tag, "_done"}, b ? fd_b : fd_a, c == len);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus_a.req_valid = '0;
        bus_a.req_data  = '0;
        bus_b.req_valid = '0;
        bus_b.req_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_ready", bus_a.req_ready, 0);
        check("rst_gid", gid_a, 0);
        check("rst_done", fd_a, 0);
        check("rst_tx_b", tx_b, 1);
        rst_n = 1'b1;

        // single byte from requester 0
        @(negedge clk);
        bus_a.req_valid = 4'b0001;
        bus_a.req_data[7:0] = 8'h55;
        #1 check("t1_ready", bus_a.req_ready, 4'b0001);
        expect_frame(0, 8'h55, 1, 0, 1, "t1");
        @(negedge clk);
        check("t1_idle_busy", busy_a, 0);
        check("t1_idle_tx", tx_a, 1);

        // all requesters valid: rotation from reset, one idle cycle between frames
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_a.req_valid = 4'b1111;
        bus_a.req_data  = 32'hA3A2A1A0;
        #1 check("t2_ready0", bus_a.req_ready, 4'b0001);
        for (int f = 0; f < 5; f++) begin
            logic [7:0] bv;
            bv = 8'hA0 + 8'(f % 4);
            expect_frame(0, bv, 1, f % 4, 0, "t2");
            @(negedge clk);
            check("t2_gap_tx", tx_a, 1);
            check("t2_gap_busy", busy_a, 0);
            check("t2_gap_ready", bus_a.req_ready, 4'b0001 << ((f + 1) % 4));
        end
        bus_a.req_valid = '0;

        // after requester 2, requester 3 wins over requester 1
        @(negedge clk);
        bus_a.req_valid = 4'b0100;
        bus_a.req_data  = 32'hC3_3C_81_00;
        #1 check("t3_ready2", bus_a.req_ready, 4'b0100);
        expect_frame(0, 8'h3C, 1, 2, 1, "t3a");
        @(negedge clk);
        bus_a.req_valid = 4'b1010;
        #1 check("t3_ready3", bus_a.req_ready, 4'b1000);
        expect_frame(0, 8'hC3, 1, 3, 0, "t3b");
        @(negedge clk);
        check("t3_ready1", bus_a.req_ready, 4'b0010);
        expect_frame(0, 8'h81, 1, 1, 1, "t3c");

        // reset during data bit 3 aborts the frame
        @(negedge clk);
        bus_a.req_valid = 4'b0001;
        bus_a.req_data  = 32'h0;
        #1 check("t4_ready", bus_a.req_ready, 4'b0001);
        @(posedge clk);
        #1 bus_a.req_valid = '0;
        repeat (70) @(negedge clk);
        check("t4_pre_tx", tx_a, 0);
        check("t4_pre_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("t4_abort_tx", tx_a, 1);
        check("t4_abort_busy", busy_a, 0);
        check("t4_abort_done", fd_a, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_hold_tx", tx_a, 1);
            check("t4_hold_done", fd_a, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_rel_tx", tx_a, 1);
        bus_a.req_valid = 4'b0011;
        bus_a.req_data  = 32'h0000_A5_5A;
        #1 check("t4_ready0", bus_a.req_ready, 4'b0001);
        expect_frame(0, 8'h5A, 1, 0, 0, "t4");
        @(negedge clk);
        check("t4_ready1", bus_a.req_ready, 4'b0010);
        bus_a.req_valid = '0;

        // 0x07: parity bit is 1 when parity is built in
        @(negedge clk);
        bus_a.req_valid = 4'b0001;
        bus_a.req_data  = 32'h07;
        #1 check("t5_ready", bus_a.req_ready, 4'b0001);
        expect_frame(0, 8'h07, 1, 0, 1, "t5");
        @(negedge clk);
        check("t5_idle_busy", busy_a, 0);
        check("t5_idle_tx", tx_a, 1);

        // two stop bits: frame ends at 176, ready again at 177
        bus_b.req_valid = 4'b0001;
        bus_b.req_data  = 32'hFF;
        #1 check("t6_ready", bus_b.req_ready, 4'b0001);
        expect_frame(1, 8'hFF, 2, 0, 0, "t6");
        @(negedge clk);
        check("t6_ready_next", bus_b.req_ready, 4'b0001);
        check("t6_idle_busy", busy_b, 0);
        bus_b.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
